// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/immediate enums, the decode
// bundle, and immediate/ALU-op helper functions.
package rv32_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        alu_op_e         alu_op;
        logic            alu_src_imm;
        logic            reg_we;
        logic            mem_re;
        logic            mem_we;
        logic            branch;
        logic            jump;
        logic [2:0]      funct3;
        logic            illegal;
    } id_bundle_t;

    function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ins, input imm_type_e t);
        case (t)
            IMM_I:   return {{20{ins[31]}}, ins[31:20]};
            IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   return {ins[31:12], 12'b0};
            IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    // alt is funct7[5]; it selects SUB only for register-register ops.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt, input logic is_op);
        case (f3)
            3'b000:  return (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 integer register file: x0 hardwired to zero, two combinational read
// ports with same-cycle write-back bypass.
module regfile
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    output logic [XLEN-1:0] rs1_val_o,
    output logic [XLEN-1:0] rs2_val_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i && wa_i != 5'd0) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rs1_val_o = '0;
        rs2_val_o = '0;
        if (rs1_i != 5'd0) rs1_val_o = (we_i && wa_i == rs1_i) ? wd_i : regs_q[rs1_i];
        if (rs2_i != 5'd0) rs2_val_o = (we_i && wa_i == rs2_i) ? wd_i : regs_q[rs2_i];
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID capture, decode, register read with bypass, and a
// registered bundle toward execute under valid/ready with stall and flush.
module id_stage
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    input  logic        ex_ready,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [31:0] id_rs1_val,
    output logic [31:0] id_rs2_val,
    output logic [31:0] id_imm,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src_imm,
    output logic        id_reg_we,
    output logic        id_mem_re,
    output logic        id_mem_we,
    output logic        id_branch,
    output logic        id_jump,
    output logic [2:0]  id_funct3,
    output logic        id_illegal
);

    logic        valid_q, valid_d;
    id_bundle_t  bundle_q, bundle_d, dec;
    imm_type_e   imm_type;
    logic [31:0] rf_rs1_val, rf_rs2_val;
    logic        load;

    assign id_ready = !valid_q || ex_ready;
    assign load     = if_valid && id_ready && !flush;

    regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1_i     (if_instr[19:15]),
        .rs2_i     (if_instr[24:20]),
        .rs1_val_o (rf_rs1_val),
        .rs2_val_o (rf_rs2_val),
        .we_i      (wb_we),
        .wa_i      (wb_rd),
        .wd_i      (wb_data)
    );

    always_comb begin
        dec         = '0;
        imm_type    = IMM_I;
        dec.pc      = if_pc;
        dec.rd      = if_instr[11:7];
        dec.funct3  = if_instr[14:12];
        dec.rs1     = if_instr[19:15];
        dec.rs2     = if_instr[24:20];
        dec.rs1_val = rf_rs1_val;
        dec.rs2_val = rf_rs2_val;
        dec.alu_op  = ALU_ADD;
        case (if_instr[6:0])
            OPC_LUI:    begin imm_type = IMM_U; dec.alu_op = ALU_PASSB; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1; end
            OPC_AUIPC:  begin imm_type = IMM_U; dec.alu_src_imm = 1'b1; dec.reg_we = 1'b1; end
            OPC_JAL:    begin imm_type = IMM_J; dec.jump = 1'b1; dec.reg_we = 1'b1; end
            OPC_JALR:   begin dec.jump = 1'b1; dec.reg_we = 1'b1; dec.alu_src_imm = 1'b1; end
            OPC_BRANCH: begin imm_type = IMM_B; dec.branch = 1'b1; end
            OPC_LOAD:   begin dec.mem_re = 1'b1; dec.reg_we = 1'b1; dec.alu_src_imm = 1'b1; end
            OPC_STORE:  begin imm_type = IMM_S; dec.mem_we = 1'b1; dec.alu_src_imm = 1'b1; end
            OPC_OPIMM: begin
                dec.alu_op      = alu_from_f3(if_instr[14:12], if_instr[30], 1'b0);
                dec.alu_src_imm = 1'b1;
                dec.reg_we      = 1'b1;
            end
            OPC_OP: begin
                dec.alu_op = alu_from_f3(if_instr[14:12], if_instr[30], 1'b1);
                dec.reg_we = 1'b1;
            end
            default:    dec.illegal = 1'b1;
        endcase
        dec.imm = imm_gen(if_instr, imm_type);
    end

    // A stalled bundle snoops write-back so execute never sees a stale operand.
    always_comb begin
        bundle_d = bundle_q;
        if (load) begin
            bundle_d = dec;
        end else if (valid_q && !ex_ready && wb_we && wb_rd != 5'd0) begin
            if (wb_rd == bundle_q.rs1) bundle_d.rs1_val = wb_data;
            if (wb_rd == bundle_q.rs2) bundle_d.rs2_val = wb_data;
        end
        if (flush)         valid_d = 1'b0;
        else if (load)     valid_d = 1'b1;
        else if (ex_ready) valid_d = 1'b0;
        else               valid_d = valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign id_valid       = valid_q;
    assign id_pc          = bundle_q.pc;
    assign id_rs1         = bundle_q.rs1;
    assign id_rs2         = bundle_q.rs2;
    assign id_rd          = bundle_q.rd;
    assign id_rs1_val     = bundle_q.rs1_val;
    assign id_rs2_val     = bundle_q.rs2_val;
    assign id_imm         = bundle_q.imm;
    assign id_alu_op      = bundle_q.alu_op;
    assign id_alu_src_imm = bundle_q.alu_src_imm;
    assign id_reg_we      = bundle_q.reg_we;
    assign id_mem_re      = bundle_q.mem_re;
    assign id_mem_we      = bundle_q.mem_we;
    assign id_branch      = bundle_q.branch;
    assign id_jump        = bundle_q.jump;
    assign id_funct3      = bundle_q.funct3;
    assign id_illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage with hand-computed decode results.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        ex_ready;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_val, id_rs2_val, id_imm;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_imm, id_reg_we, id_mem_re, id_mem_we, id_branch, id_jump;
    logic [2:0]  id_funct3;
    logic        id_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src_imm(id_alu_src_imm), .id_reg_we(id_reg_we),
        .id_mem_re(id_mem_re), .id_mem_we(id_mem_we), .id_branch(id_branch), .id_jump(id_jump),
        .id_funct3(id_funct3), .id_illegal(id_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        ex_ready = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        #2;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", id_valid); end
        checks++; if ({id_pc, id_imm, id_rs1_val, id_rs2_val} !== 128'd0) begin errors++; $display("FAIL reset_data got %h %h want 0", id_pc, id_imm); end
        checks++; if ({id_alu_op, id_illegal, id_reg_we, id_mem_we, id_jump} !== 8'd0) begin errors++; $display("FAIL reset_ctrl got alu=%0d ill=%0b want 0", id_alu_op, id_illegal); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", id_ready); end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_addi();
        if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h100;
        step();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b want 1", id_valid); end
        checks++; if (id_rd !== 5'd1 || id_imm !== 32'd5 || id_pc !== 32'h100) begin errors++; $display("FAIL addi_fields got rd=%0d imm=%h pc=%h want 1 5 100", id_rd, id_imm, id_pc); end
        checks++; if (id_alu_op !== 4'd0 || id_alu_src_imm !== 1'b1 || id_reg_we !== 1'b1) begin errors++; $display("FAIL addi_ctrl got alu=%0d src=%0b we=%0b want 0 1 1", id_alu_op, id_alu_src_imm, id_reg_we); end
        checks++; if (id_rs1 !== 5'd0 || id_rs1_val !== 32'd0 || id_illegal !== 1'b0) begin errors++; $display("FAIL addi_rs1 got rs1=%0d val=%h ill=%0b want 0 0 0", id_rs1, id_rs1_val, id_illegal); end
    endtask

    task automatic test_store();
        if_instr = 32'hFE20AE23; if_pc = 32'h104;
        step();
        checks++; if (id_imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_imm got %h want fffffffc", id_imm); end
        checks++; if (id_mem_we !== 1'b1 || id_reg_we !== 1'b0 || id_mem_re !== 1'b0) begin errors++; $display("FAIL sw_ctrl got mw=%0b rw=%0b mr=%0b want 1 0 0", id_mem_we, id_reg_we, id_mem_re); end
        checks++; if (id_rs1 !== 5'd1 || id_rs2 !== 5'd2 || id_funct3 !== 3'd2) begin errors++; $display("FAIL sw_regs got rs1=%0d rs2=%0d f3=%0d want 1 2 2", id_rs1, id_rs2, id_funct3); end
    endtask

    task automatic test_bypass();
        if_instr = 32'h00318233; if_pc = 32'h108;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        step();
        wb_we = 1'b0;
        checks++; if (id_rs1_val !== 32'hDEADBEEF || id_rs2_val !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_vals got %h %h want deadbeef", id_rs1_val, id_rs2_val); end
        checks++; if (id_rd !== 5'd4 || id_alu_op !== 4'd0 || id_alu_src_imm !== 1'b0) begin errors++; $display("FAIL bypass_ctrl got rd=%0d alu=%0d src=%0b want 4 0 0", id_rd, id_alu_op, id_alu_src_imm); end
    endtask

    task automatic test_stall_refresh();
        ex_ready = 1'b0; if_instr = 32'h00500093; if_pc = 32'h10C;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0b want 0", id_ready); end
        step();
        wb_we = 1'b0;
        checks++; if (id_rs1_val !== 32'h1234 || id_rs2_val !== 32'h1234) begin errors++; $display("FAIL refresh_vals got %h %h want 1234", id_rs1_val, id_rs2_val); end
        checks++; if (id_valid !== 1'b1 || id_rd !== 5'd4 || id_pc !== 32'h108) begin errors++; $display("FAIL stall_hold got v=%0b rd=%0d pc=%h want 1 4 108", id_valid, id_rd, id_pc); end
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h5555;
        step();
        wb_we = 1'b0;
        checks++; if (id_rs1_val !== 32'h1234 || id_rs2_val !== 32'h1234) begin errors++; $display("FAIL refresh_other got %h %h want 1234", id_rs1_val, id_rs2_val); end
        ex_ready = 1'b1; if_valid = 1'b0;
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b want 0", id_valid); end
    endtask

    task automatic test_flush();
        if_valid = 1'b1; if_instr = 32'h123452B7; if_pc = 32'h200; flush = 1'b1;
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", id_valid); end
        flush = 1'b0;
        step();
        checks++; if (id_valid !== 1'b1 || id_imm !== 32'h12345000) begin errors++; $display("FAIL lui_imm got v=%0b imm=%h want 1 12345000", id_valid, id_imm); end
        checks++; if (id_alu_op !== 4'd10 || id_rd !== 5'd5) begin errors++; $display("FAIL lui_ctrl got alu=%0d rd=%0d want 10 5", id_alu_op, id_rd); end
        // flush together with a stalled bundle
        ex_ready = 1'b0; flush = 1'b1;
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", id_valid); end
        ex_ready = 1'b1; flush = 1'b0;
    endtask

    task automatic test_illegal();
        if_instr = 32'h0000007F; if_pc = 32'h300;
        step();
        checks++; if (id_illegal !== 1'b1 || id_valid !== 1'b1) begin errors++; $display("FAIL illegal_flag got ill=%0b v=%0b want 1 1", id_illegal, id_valid); end
        checks++; if ({id_reg_we, id_mem_re, id_mem_we, id_branch, id_jump} !== 5'b0) begin errors++; $display("FAIL illegal_ctrl got %b want 00000", {id_reg_we, id_mem_re, id_mem_we, id_branch, id_jump}); end
    endtask

    task automatic test_x0();
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF; if_instr = 32'h00500093;
        step();
        checks++; if (id_rs1_val !== 32'd0) begin errors++; $display("FAIL x0_bypass got %h want 0", id_rs1_val); end
        wb_we = 1'b0; if_instr = 32'h00000333;
        step();
        checks++; if (id_rs1_val !== 32'd0 || id_rs2_val !== 32'd0) begin errors++; $display("FAIL x0_read got %h %h want 0", id_rs1_val, id_rs2_val); end
        if_instr = 32'h00318233;
        step();
        checks++; if (id_rs1_val !== 32'h1234 || id_rs2_val !== 32'h1234) begin errors++; $display("FAIL x3_stored got %h %h want 1234", id_rs1_val, id_rs2_val); end
    endtask

    task automatic test_back_to_back();
        if_instr = 32'h00208463; if_pc = 32'h400;
        step();
        checks++; if (id_branch !== 1'b1 || id_imm !== 32'd8 || id_reg_we !== 1'b0 || id_pc !== 32'h400) begin errors++; $display("FAIL beq got br=%0b imm=%h we=%0b pc=%h want 1 8 0 400", id_branch, id_imm, id_reg_we, id_pc); end
        if_instr = 32'h40208033; if_pc = 32'h404;
        step();
        checks++; if (id_alu_op !== 4'd1 || id_pc !== 32'h404 || id_valid !== 1'b1) begin errors++; $display("FAIL sub got alu=%0d pc=%h v=%0b want 1 404 1", id_alu_op, id_pc, id_valid); end
        if_instr = 32'h4030D093; if_pc = 32'h408;
        step();
        checks++; if (id_alu_op !== 4'd7 || id_imm !== 32'h403 || id_funct3 !== 3'd5) begin errors++; $display("FAIL srai got alu=%0d imm=%h f3=%0d want 7 403 5", id_alu_op, id_imm, id_funct3); end
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (id_valid !== 1'b0 || id_pc !== 32'd0 || id_alu_op !== 4'd0) begin errors++; $display("FAIL midreset got v=%0b pc=%h alu=%0d want 0 0 0", id_valid, id_pc, id_alu_op); end
        if_valid = 1'b0;
        step();
        rst_n = 1'b1; if_valid = 1'b1; if_instr = 32'h00318233;
        step();
        checks++; if (id_rs1_val !== 32'd0 || id_rs2_val !== 32'd0 || id_valid !== 1'b1) begin errors++; $display("FAIL rf_cleared got %h %h v=%0b want 0 0 1", id_rs1_val, id_rs2_val, id_valid); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_bypass();
        test_stall_refresh();
        test_flush();
        test_illegal();
        test_x0();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 32-bit RISC-V pipeline, directly downstream of the fetch stage. It consumes the fetched instruction and PC, holds them in the IF/ID pipeline register, and decodes the RV32I base set into control signals and a sign-extended immediate. It also contains the integer register file, reading rs1/rs2 with write-back bypass. It presents a registered decode bundle to the execute stage under a valid/ready handshake with stall and flush.

## Interface
- No parameters. XLEN = 32 and 32 architectural registers are fixed.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- if_valid  in  1  fetch presents a valid instruction.
- if_instr  in  32  fetched instruction.
- if_pc  in  32  PC of if_instr.
- id_ready  out  1  stage accepts input this cycle; fetch stalls when low.
- ex_ready  in  1  execute accepts the current output.
- flush  in  1  kill the contents of this stage (taken branch or jump).
- wb_we  in  1  write-back enable.
- wb_rd  in  5  write-back destination.
- wb_data  in  32  write-back value.
- id_valid  out  1  output bundle valid.
- id_pc  out  32  PC of the decoded instruction.
- id_rs1, id_rs2, id_rd  out  5 each  register indices.
- id_rs1_val, id_rs2_val  out  32 each  operand values.
- id_imm  out  32  sign-extended immediate.
- id_alu_op  out  4  ALU operation (package enum).
- id_alu_src_imm  out  1  ALU operand B is id_imm.
- id_reg_we, id_mem_re, id_mem_we, id_branch, id_jump  out  1 each  control flags.
- id_funct3  out  3  forwarded to the branch and memory units.
- id_illegal  out  1  unsupported opcode.

## Operation
- load = if_valid && id_ready && !flush; id_ready = !id_valid || ex_ready.
- On load, all outputs are registered from the decode of if_instr, and id_valid <= 1.
- If ex_ready is high with no load, id_valid <= 0.
- Otherwise the outputs hold.
- flush has priority: id_valid <= 0 next cycle, and any load that cycle is discarded.
- Immediate formats:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All formats are sign-extended from bit 31.
- Opcode decode:
  - LUI 0110111 → alu PASSB.
  - AUIPC 0010111 → ADD.
  - JAL 1101111 and JALR 1100111 → jump, reg_we.
  - BRANCH 1100011 → branch.
  - LOAD 0000011 → mem_re, reg_we.
  - STORE 0100011 → mem_we.
  - OP-IMM 0010011 → alu_src_imm, reg_we.
  - OP 0110011 → reg_we.
- ALU op comes from funct3, plus funct7[5] for SUB (OP only) and SRA (both OP and OP-IMM).
- Any other opcode sets id_illegal = 1 and forces reg_we, mem_re, mem_we, branch and jump to 0.
- Register file, 32×32:
  - x0 reads 0 and ignores writes.
  - Written at posedge when wb_we && wb_rd != 0.
  - Read is combinational.
  - Bypass: if wb_we && wb_rd == rs && rs != 0, the read returns wb_data in the same cycle.
- Stale-operand refresh: while a valid bundle is held (id_valid && !ex_ready), a write-back with wb_rd == id_rs1 (or id_rs2), nonzero, updates id_rs1_val (or id_rs2_val) to wb_data.

## Timing
- Latency is 1 cycle from a load cycle to id_valid and the bundle.
- Reset: all outputs are 0, including id_valid, id_illegal and id_alu_op (= ADD = 0). All registers x1..x31 are cleared to 0.
- Reset asserted mid-operation drops any held bundle immediately, with no partial decode.
- Back-to-back throughput is 1 instruction per cycle while ex_ready = 1.
- Simultaneous flush and ex_ready: id_valid <= 0.
- Simultaneous load and write-back to an accessed rs: the bundle captures wb_data.

## Structure
- Shared package rv32_pkg holds:
  - opcode localparams;
  - alu_op_e enum (ADD=0, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB);
  - imm_type_e enum (I, S, B, U, J);
  - id_bundle_t struct.
- One sub-module: regfile (two read ports, one write port, bypass inside).

## Test plan
- Reset, then if_valid with 0x00500093 (addi x1,x0,5): next cycle id_valid=1, rd=1, imm=5, alu ADD, alu_src_imm=1, reg_we=1.
- 0xFE20AE23 (sw x2,-4(x1)): imm=0xFFFFFFFC, mem_we=1, reg_we=0, rs1=1, rs2=2.
- wb_we=1, rd=3, data=0xDEADBEEF in the same cycle as load of 0x00318233 (add x4,x3,x3): both operand values = 0xDEADBEEF.
- Hold ex_ready=0 with the bundle from the previous case, then write-back x3=0x1234: both values update to 0x1234, id_ready=0, and the bundle otherwise holds.
- Load 0x123452B7 (lui x5,0x12345) with flush=1 in the same cycle: id_valid=0 next cycle. Repeat without flush: imm=0x12345000, alu PASSB.
- Load 0x0000007F: id_illegal=1 and all control writes 0. Writes to x0 read back 0.
